mem_load_size: RTL

//   Read-side counterpart of the memory write-data path. On a load request it strobes
//   a memory read and waits the fixed memory latency. It then samples the returned
//   32-bit word, extracts the byte, halfword or word selected by the address offset,

---
 rtl/mem_load_size_if.sv | 30 +++
 rtl/mem_load_size.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_load_size_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_size_if
// Description : Request/response bundle between the load sequencer and its
//               requester/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_load_size_if;
  logic        start;
  logic [1:0]  load_type;
  logic [1:0]  byte_off;
  logic        signed_en;
  logic [31:0] mem_data_in;
  logic        mem_rd;
  logic        busy;
  logic        done;
  logic [31:0] load_out;
  logic        misalign_err;

  modport master (
    output start, load_type, byte_off, signed_en, mem_data_in,
    input  mem_rd, busy, done, load_out, misalign_err
  );

  modport slave (
    input  start, load_type, byte_off, signed_en, mem_data_in,
    output mem_rd, busy, done, load_out, misalign_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_load_size.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_size
// Description : Multicycle load sequencer: strobes a memory read, waits the
//               fixed latency, then extracts and extends byte/half/word.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_size #(
  parameter int MEM_LATENCY = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,
  mem_load_size_if.slave   ld_if
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] LT_LW = 2'b00;
  localparam logic [1:0] LT_LH = 2'b01;
  localparam logic [1:0] LT_LB = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             latch_en;
  logic             misaligned;

  logic [1:0]       type_q;
  logic [1:0]       off_q;
  logic             sgn_q;

  logic             mem_rd_q;
  logic             busy_q;
  logic             done_q;
  logic             misalign_q;
  logic [31:0]      load_out_q;

  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_ext;

  // Alignment is judged on the live request so a bad access never touches memory
  always_comb begin
    misaligned = 1'b0;
    case (ld_if.load_type)
      LT_LH:   misaligned = ld_if.byte_off[0];
      LT_LB:   misaligned = 1'b0;
      default: misaligned = (ld_if.byte_off != 2'b00);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (ld_if.start) begin
          latch_en = 1'b1;
          state_d  = misaligned ? ERR : READ;
        end
      end
      READ: begin
        cnt_d   = CNT_INIT;
        state_d = (MEM_LATENCY == 1) ? CAPT : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = CAPT;
        end
      end
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at acceptance; later input changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      type_q <= LT_LW;
      off_q  <= 2'b00;
      sgn_q  <= 1'b0;
    end else if (latch_en) begin
      type_q <= ld_if.load_type;
      off_q  <= ld_if.byte_off;
      sgn_q  <= ld_if.signed_en;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (off_q)
      2'd0:    byte_sel = ld_if.mem_data_in[7:0];
      2'd1:    byte_sel = ld_if.mem_data_in[15:8];
      2'd2:    byte_sel = ld_if.mem_data_in[23:16];
      default: byte_sel = ld_if.mem_data_in[31:24];
    endcase
    half_sel = off_q[1] ? ld_if.mem_data_in[31:16] : ld_if.mem_data_in[15:0];
    case (type_q)
      LT_LB:   load_ext = {{24{sgn_q & byte_sel[7]}}, byte_sel};
      LT_LH:   load_ext = {{16{sgn_q & half_sel[15]}}, half_sel};
      default: load_ext = ld_if.mem_data_in;
    endcase
  end

  // Outputs are registered from the next state so they line up with it cycle-for-cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rd_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      load_out_q <= 32'h0000_0000;
    end else begin
      mem_rd_q   <= (state_d == READ);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE) || (state_d == ERR);
      misalign_q <= (state_d == ERR);
      if (state_q == CAPT) begin
        load_out_q <= load_ext;
      end
    end
  end

  assign ld_if.mem_rd       = mem_rd_q;
  assign ld_if.busy         = busy_q;
  assign ld_if.done         = done_q;
  assign ld_if.misalign_err = misalign_q;
  assign ld_if.load_out     = load_out_q;

endmodule
`default_nettype wire
